// File: rtl/fill_control_pkg.sv
// Shared definitions for the tank fill and drain controllers: state encoding,
// inlet speed codes and level constants.
package fill_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAULT   = 2'd3
  } fill_state_t;

  typedef enum logic [1:0] {
    RATE_NONE   = 2'd0,
    RATE_SLOW   = 2'd1,
    RATE_MEDIUM = 2'd2,
    RATE_FAST   = 2'd3
  } inflow_rate_t;

  localparam logic [3:0] MAX_LEVEL  = 4'd15;
  localparam logic [3:0] SAFE_LEVEL = 4'd6;

endpackage

// File: rtl/fill_control_stall_counter.sv
// Counts consecutive zero-inflow ticks; terminal flags that the next enabled
// count will reach LIMIT, so the FSM can fault on that same edge.
module stall_counter #(
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [3:0] count;

  assign terminal = (count == 4'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (en && (count != 4'd15)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/fill_control.sv
// Tank fill controller: opens the inlet until the level reaches TARGET_LEVEL,
// faulting if the inflow stalls for STALL_TICKS consecutive ticks.
module fill_control
  import fill_control_pkg::*;
#(
  parameter int TARGET_LEVEL = 12,
  parameter int STALL_TICKS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] level_in,
  input  logic [1:0] inflow_rate,
  output logic       valve,
  output logic [3:0] water_level,
  output logic       full,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [3:0] TARGET4 = 4'(TARGET_LEVEL);
  localparam logic [4:0] TARGET5 = 5'(TARGET_LEVEL);

  logic [1:0]  rst_sync;
  logic        rst_n;
  fill_state_t state_q, next_state;
  logic [3:0]  next_level;
  logic [4:0]  sum;
  logic        stall_clear, stall_en, stall_terminal;

  // Reset asserts immediately but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  stall_counter #(.LIMIT(STALL_TICKS)) u_stall (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (stall_clear),
    .en       (stall_en),
    .terminal (stall_terminal)
  );

  assign sum = {1'b0, water_level} + {3'b000, inflow_rate};

  always_comb begin
    next_state  = state_q;
    next_level  = water_level;
    stall_clear = 1'b0;
    stall_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (load) begin
            next_level = level_in;
          end else if (start) begin
            stall_clear = 1'b1;
            next_state  = (water_level < TARGET4) ? ST_FILLING : ST_FULL;
          end
        end
      end
      ST_FILLING: begin
        if (stop) begin
          next_state = ST_IDLE;
        end else if (tick) begin
          if (sum >= TARGET5) begin
            next_level = TARGET4;
            next_state = ST_FULL;
          end else begin
            next_level = sum[3:0];
            if (inflow_rate == RATE_NONE) begin
              stall_en = 1'b1;
              if (stall_terminal) begin
                next_state = ST_FAULT;
              end
            end else begin
              stall_clear = 1'b1;
            end
          end
        end
      end
      ST_FULL: begin
        if (stop) begin
          next_state = ST_IDLE;
        end else if (load) begin
          next_level = level_in;
          if (level_in < TARGET4) begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (stop) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      water_level <= 4'd0;
      valve       <= 1'b0;
      full        <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= next_state;
      water_level <= next_level;
      valve       <= (next_state == ST_FILLING);
      full        <= (next_state == ST_FULL);
      alarm       <= (next_state == ST_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fill_control.sv
// Directed bench for fill_control: each task drives one scenario and checks
// level, state and output flags against hand-computed values.
module tb_fill_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [3:0] level_in = 4'd0;
  logic [1:0] inflow_rate = 2'd0;
  logic       valve, full, alarm;
  logic [3:0] water_level;
  logic [1:0] state;
  int checks = 0;
  int passes = 0;

  fill_control dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .load(load),
    .level_in(level_in), .inflow_rate(inflow_rate), .valve(valve),
    .water_level(water_level), .full(full), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  // Inputs are applied after a falling edge, captured on the rising edge and
  // observed on the following falling edge.
  task automatic drive(input logic st, sp, ld, tk, input logic [3:0] lv, input logic [1:0] rt);
    start = st; stop = sp; load = ld; tick = tk; level_in = lv; inflow_rate = rt;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; load = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", state); else passes++;
    checks++; if (water_level !== 4'd0) $display("[TB] FAIL reset_level: got %0d want 0", water_level); else passes++;
    checks++; if ({valve, full, alarm} !== 3'b000) $display("[TB] FAIL reset_flags: got %b want 000", {valve, full, alarm}); else passes++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fill();
    drive(0, 0, 1, 0, 4'd6, 2'd3);
    checks++; if (water_level !== 4'd6) $display("[TB] FAIL fill_load: got %0d want 6", water_level); else passes++;
    drive(1, 0, 0, 0, 4'd0, 2'd3);
    checks++; if ({state, valve} !== {2'd1, 1'b1}) $display("[TB] FAIL fill_start: got state %0d valve %b want 1/1", state, valve); else passes++;
    drive(0, 0, 0, 1, 4'd0, 2'd3);
    checks++; if (water_level !== 4'd9) $display("[TB] FAIL fill_tick1: got %0d want 9", water_level); else passes++;
    drive(0, 0, 0, 1, 4'd0, 2'd3);
    checks++; if (water_level !== 4'd12) $display("[TB] FAIL fill_tick2: got %0d want 12", water_level); else passes++;
    checks++; if ({state, full, valve} !== {2'd2, 1'b1, 1'b0}) $display("[TB] FAIL fill_full: got state %0d full %b valve %b want 2/1/0", state, full, valve); else passes++;
  endtask

  task automatic test_saturate();
    drive(0, 0, 1, 0, 4'd10, 2'd3);
    checks++; if ({state, water_level} !== {2'd0, 4'd10}) $display("[TB] FAIL full_load_low: got state %0d level %0d want 0/10", state, water_level); else passes++;
    drive(1, 0, 0, 0, 4'd0, 2'd3);
    drive(0, 0, 0, 1, 4'd0, 2'd3);
    checks++; if ({state, water_level} !== {2'd2, 4'd12}) $display("[TB] FAIL saturate: got state %0d level %0d want 2/12", state, water_level); else passes++;
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 0, 4'd10, 2'd0);
    drive(1, 0, 0, 0, 4'd0, 2'd0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 4'd0, 2'd0);
    checks++; if ({state, water_level} !== {2'd1, 4'd10}) $display("[TB] FAIL stall_9: got state %0d level %0d want 1/10", state, water_level); else passes++;
    drive(0, 0, 0, 1, 4'd0, 2'd0);
    checks++; if ({state, alarm, valve} !== {2'd3, 1'b1, 1'b0}) $display("[TB] FAIL stall_fault: got state %0d alarm %b valve %b want 3/1/0", state, alarm, valve); else passes++;
    drive(1, 0, 1, 1, 4'd2, 2'd3);
    checks++; if ({state, water_level} !== {2'd3, 4'd10}) $display("[TB] FAIL fault_hold: got state %0d level %0d want 3/10", state, water_level); else passes++;
    drive(0, 1, 0, 0, 4'd0, 2'd0);
    checks++; if ({state, alarm, water_level} !== {2'd0, 1'b0, 4'd10}) $display("[TB] FAIL fault_stop: got state %0d alarm %b level %0d want 0/0/10", state, alarm, water_level); else passes++;
  endtask

  task automatic test_stall_clear();
    drive(0, 0, 1, 0, 4'd0, 2'd0);
    drive(1, 0, 0, 0, 4'd0, 2'd0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 4'd0, 2'd0);
    drive(0, 0, 0, 1, 4'd0, 2'd1);
    checks++; if (water_level !== 4'd1) $display("[TB] FAIL slow_tick: got %0d want 1", water_level); else passes++;
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 4'd0, 2'd0);
    checks++; if (state !== 2'd1) $display("[TB] FAIL stall_cleared: got state %0d want 1", state); else passes++;
    drive(0, 0, 0, 1, 4'd0, 2'd0);
    checks++; if (state !== 2'd3) $display("[TB] FAIL stall_after_clear: got state %0d want 3", state); else passes++;
    drive(0, 1, 0, 0, 4'd0, 2'd0);
  endtask

  task automatic test_full_direct();
    drive(0, 0, 1, 0, 4'd13, 2'd3);
    drive(1, 0, 0, 0, 4'd0, 2'd3);
    checks++; if ({state, full, valve} !== {2'd2, 1'b1, 1'b0}) $display("[TB] FAIL direct_full: got state %0d full %b valve %b want 2/1/0", state, full, valve); else passes++;
    drive(0, 0, 1, 0, 4'd14, 2'd3);
    checks++; if ({state, water_level} !== {2'd2, 4'd14}) $display("[TB] FAIL full_load_high: got state %0d level %0d want 2/14", state, water_level); else passes++;
    drive(1, 0, 0, 1, 4'd0, 2'd3);
    checks++; if ({state, water_level} !== {2'd2, 4'd14}) $display("[TB] FAIL full_ignore_start: got state %0d level %0d want 2/14", state, water_level); else passes++;
    drive(0, 1, 0, 0, 4'd0, 2'd3);
    checks++; if ({state, full, water_level} !== {2'd0, 1'b0, 4'd14}) $display("[TB] FAIL full_stop: got state %0d full %b level %0d want 0/0/14", state, full, water_level); else passes++;
  endtask

  task automatic test_stop_priority();
    drive(0, 0, 1, 0, 4'd8, 2'd3);
    drive(1, 0, 0, 0, 4'd0, 2'd3);
    drive(0, 1, 0, 1, 4'd0, 2'd3);
    checks++; if ({state, valve, water_level} !== {2'd0, 1'b0, 4'd8}) $display("[TB] FAIL stop_tick: got state %0d valve %b level %0d want 0/0/8", state, valve, water_level); else passes++;
    drive(1, 0, 0, 1, 4'd0, 2'd3);
    checks++; if ({state, water_level} !== {2'd1, 4'd8}) $display("[TB] FAIL start_tick: got state %0d level %0d want 1/8", state, water_level); else passes++;
    drive(0, 0, 1, 0, 4'd2, 2'd3);
    checks++; if ({state, water_level} !== {2'd1, 4'd8}) $display("[TB] FAIL filling_ignore_load: got state %0d level %0d want 1/8", state, water_level); else passes++;
    drive(0, 0, 0, 1, 4'd0, 2'd3);
    checks++; if ({state, water_level} !== {2'd1, 4'd11}) $display("[TB] FAIL filling_tick: got state %0d level %0d want 1/11", state, water_level); else passes++;
  endtask

  task automatic test_reset_mid_fill();
    checks++; if (valve !== 1'b1) $display("[TB] FAIL pre_reset_valve: got %b want 1", valve); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if ({valve, state, water_level} !== {1'b0, 2'd0, 4'd0}) $display("[TB] FAIL async_reset: got valve %b state %0d level %0d want 0/0/0", valve, state, water_level); else passes++;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({state, valve} !== {2'd0, 1'b0}) $display("[TB] FAIL post_reset_idle: got state %0d valve %b want 0/0", state, valve); else passes++;
    drive(0, 0, 1, 0, 4'd5, 2'd0);
    checks++; if (water_level !== 4'd5) $display("[TB] FAIL post_reset_load: got %0d want 5", water_level); else passes++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_saturate();
    test_stall();
    test_stall_clear();
    test_full_direct();
    test_stop_priority();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fill_control.md
FILL_CONTROL -- requirements
Module: fill_control

Interface
REQ-001 Parameter TARGET_LEVEL, default 12, SHALL be the fill stop level (4-bit, 7..15).
REQ-002 Parameter STALL_TICKS, default 10, SHALL be the number of zero-inflow ticks in FILLING that raises a fault (1..15).
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 tick  input  1  1 Hz enable, one clk wide, from the 1 Hz clock divider.
REQ-006 start  input  1  debounced single-cycle start-fill request.
REQ-007 stop  input  1  debounced single-cycle abort / fault-clear request.
REQ-008 load  input  1  single-cycle load of level_in into the level register.
REQ-009 level_in  input  4  initial or sensed water level, 0..15.
REQ-010 inflow_rate  input  2  inlet speed per tick: 0 none, 1 slow, 2 medium, 3 fast.
REQ-011 valve  output  1  inlet valve drive, 1 = open.
REQ-012 water_level  output  4  current level register.
REQ-013 full  output  1  high while in FULL.
REQ-014 alarm  output  1  high while in FAULT.
REQ-015 state  output  2  encoded FSM state: IDLE=0, FILLING=1, FULL=2, FAULT=3.

Function
REQ-016 The FSM SHALL have the states IDLE, FILLING, FULL and FAULT; outputs SHALL be registered and decoded from state.
REQ-017 valve SHALL be 1 only in FILLING; full SHALL be 1 only in FULL; alarm SHALL be 1 only in FAULT.
REQ-018 Input priority within one cycle SHALL be stop > load > start > tick.
REQ-019 IDLE + load: water_level SHALL take level_in on the next edge.
REQ-020 IDLE + start: the FSM SHALL go to FILLING if water_level < TARGET_LEVEL, else to FULL, on the next edge.
REQ-021 FILLING + tick: the sum water_level + inflow_rate SHALL be computed 5 bits wide.
REQ-022 If that sum >= TARGET_LEVEL, water_level SHALL become TARGET_LEVEL and the FSM SHALL go to FULL on the same edge.
REQ-023 Otherwise water_level SHALL become the sum and the FSM SHALL stay in FILLING.
REQ-024 water_level SHALL never exceed TARGET_LEVEL through filling and SHALL never wrap.
REQ-025 FILLING + tick with inflow_rate = 0 SHALL increment the stall count.
REQ-026 FILLING + tick with nonzero inflow_rate SHALL clear the stall count.
REQ-027 When the stall count reaches STALL_TICKS, the FSM SHALL go to FAULT on that edge.
REQ-028 The stall count SHALL be cleared whenever the FSM enters FILLING.
REQ-029 In FILLING, load and start SHALL be ignored.
REQ-030 FULL + load with level_in < TARGET_LEVEL: water_level SHALL take level_in and the FSM SHALL go to IDLE.
REQ-031 FULL + load with level_in >= TARGET_LEVEL: water_level SHALL take level_in and the FSM SHALL stay in FULL.
REQ-032 In FULL, start SHALL be ignored.
REQ-033 In FAULT, water_level SHALL hold and tick, start and load SHALL be ignored.
REQ-034 stop in FILLING, FULL or FAULT SHALL return the FSM to IDLE on the next edge with water_level held.
REQ-035 The valve SHALL close in the same cycle the FSM leaves FILLING.
REQ-036 A tick coincident with start SHALL NOT advance the level; filling SHALL begin on the first tick after entering FILLING.

Reset
REQ-037 rst low SHALL asynchronously force state to IDLE, water_level to 0, stall count to 0, and valve, full and alarm to 0.
REQ-038 Reset mid-fill SHALL close the valve immediately without waiting for a clk edge.
REQ-039 Deassertion of rst SHALL be synchronised to clk by a two-flop synchroniser inside the block.

Structure
REQ-040 A shared package SHALL hold the state encoding, the inflow_rate encodings, and the constants MAX_LEVEL = 15 and SAFE_LEVEL = 6; the package SHALL be common with the drain controller.
REQ-041 The stall count SHALL be one sub-module, stall_counter: a 4-bit counter with clear, enable and terminal-flag output.
REQ-042 No other sub-module SHALL be instantiated; tick generation and debouncing SHALL stay outside the block.

Verification
REQ-043 load level_in=6, start, rate=3, 2 ticks -> level 9, then 12; FULL, full=1, valve=0 after the second tick.
REQ-044 level 10, rate=3, start, 1 tick -> level 12 (saturated, not 13); FULL.
REQ-045 FILLING, rate=0, 10 ticks -> FAULT on the 10th tick, alarm=1, valve=0; stop -> IDLE, alarm=0.
REQ-046 level 13, start -> FULL directly, valve never asserted.
REQ-047 FILLING at level 8, stop and tick in the same cycle -> IDLE, level stays 8.
REQ-048 rst low mid-FILLING between clk edges -> valve=0 immediately, level 0; after release, IDLE.
